// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, input-stream, memory-port and status signals.
// The host/testbench side takes the master modport and the loader takes the slave modport.
interface imem_loader_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] load_base;
    logic [CNT_W-1:0]  load_count;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic [31:0]       fetch_pc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, load_base, load_count, in_valid, in_data, fetch_pc,
        input  in_ready, mem_addr, mem_we, mem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, load_base, load_count, in_valid, in_data, fetch_pc,
        output in_ready, mem_addr, mem_we, mem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader. It takes 32-bit words from a valid/ready
// stream and writes each word big-endian as four byte writes. While a load is
// running it owns the shared memory address port and holds the CPU.
module imem_loader #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    // Wide enough that base + 4*count can never wrap.
    localparam int EW = ADDR_W + CNT_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0]  rem_q;
    logic [31:0]       word_q;
    logic [1:0]        idx_q;
    logic              loaded_q;
    logic              err_q;
    logic              done_q;

    logic [EW-1:0]     span_end_d;
    logic [EW-1:0]     mem_size;
    logic              req_bad_d;
    logic [7:0]        wdata_d;
    logic              unused_pc_hi;

    assign span_end_d = EW'(bus.load_base) + EW'({bus.load_count, 2'b00});
    assign mem_size   = EW'(1) << ADDR_W;
    assign req_bad_d  = (bus.load_base[1:0] != 2'b00) || (span_end_d > mem_size);

    // Load sequencer: request check, word handshake, 4-byte write burst, completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (req_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q    <= 1'b0;
                            wr_ptr_q <= bus.load_base;
                            rem_q    <= bus.load_count;
                            if (bus.load_count == '0) begin
                                done_q  <= 1'b1;
                                state_q <= FINISH;
                            end else begin
                                state_q <= WAIT_WORD;
                            end
                        end
                    end
                end
                WAIT_WORD: begin
                    if (bus.in_valid) begin
                        word_q  <= bus.in_data;
                        idx_q   <= 2'd0;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Pointer may wrap past the top of memory on the final word; it is never used again.
                        wr_ptr_q <= wr_ptr_q + ADDR_W'(4);
                        rem_q    <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            state_q <= WAIT_WORD;
                        end
                    end
                end
                FINISH: begin
                    done_q   <= 1'b0;
                    loaded_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Big-endian byte select for the current write beat.
    always_comb begin
        wdata_d = 8'h00;
        if (state_q == WRITE) begin
            case (idx_q)
                2'd0:    wdata_d = word_q[31:24];
                2'd1:    wdata_d = word_q[23:16];
                2'd2:    wdata_d = word_q[15:8];
                default: wdata_d = word_q[7:0];
            endcase
        end
    end

    assign unused_pc_hi = ^bus.fetch_pc[31:ADDR_W];

    // The fetch PC owns the address port whenever the loader is idle.
    assign bus.mem_addr  = (state_q == IDLE) ? bus.fetch_pc[ADDR_W-1:0]
                                             : wr_ptr_q + ADDR_W'(idx_q);
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_wdata = wdata_d;
    assign bus.in_ready  = (state_q == WAIT_WORD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cpu_hold  = (state_q != IDLE) || !loaded_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of load requests with expected outcomes,
// plus hand sequences for reset mid-load and the fetch-PC address mux.
module tb_imem_loader;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wq[$];

    // Record every byte write seen on the memory port.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) wq.push_back('{bus.mem_addr, bus.mem_wdata});
    end

    typedef struct {
        logic [13:0] base;
        logic [11:0] cnt;
        logic [31:0] w0;
        logic [31:0] w1;
        int          vdly;
        bit          poke;
        bit          exp_err;
        int          exp_nw;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input vec_t v, input string tag);
        logic [31:0] words[2];
        logic [31:0] wd;
        int lat;
        int guard;
        words[0] = v.w0;
        words[1] = v.w1;
        wq.delete();
        bus.start = 1'b1; bus.load_base = v.base; bus.load_count = v.cnt;
        step();
        bus.start = 1'b0;
        chk({tag, " err"}, 32'(bus.err), 32'(v.exp_err));
        chk({tag, " busy"}, 32'(bus.busy), 32'(!v.exp_err));
        if (v.exp_err) begin
            for (int c = 0; c < 3; c++) begin
                step();
                chk({tag, " busy stays low"}, 32'(bus.busy), 32'd0);
            end
        end else if (v.cnt == 0) begin
            chk({tag, " done T+1"}, 32'(bus.done), 32'd1);
            step();
            chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
            chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
            chk({tag, " cpu_hold end"}, 32'(bus.cpu_hold), 32'd0);
        end else begin
            lat = 0;
            for (int w = 0; w < int'(v.cnt); w++) begin
                guard = 0;
                while (bus.in_ready !== 1'b1 && guard < 20) begin step(); guard++; end
                chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
                for (int d = 0; d < v.vdly; d++) begin
                    if (v.poke && d == 0) begin
                        bus.start = 1'b1; bus.load_base = 14'h0; bus.load_count = 12'd5;
                    end
                    step();
                    bus.start = 1'b0;
                    chk({tag, " no write while waiting"}, 32'(bus.mem_we), 32'd0);
                    chk({tag, " ready held"}, 32'(bus.in_ready), 32'd1);
                end
                bus.in_valid = 1'b1; bus.in_data = words[w];
                step();
                bus.in_valid = 1'b0;
                lat = 1;
            end
            while (bus.done !== 1'b1 && lat < 20) begin step(); lat++; end
            chk({tag, " done latency"}, 32'(lat), 32'd5);
            chk({tag, " hold at done"}, 32'(bus.cpu_hold), 32'd1);
            step();
            chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
            chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
            chk({tag, " cpu_hold end"}, 32'(bus.cpu_hold), 32'd0);
        end
        chk({tag, " write count"}, 32'(wq.size()), 32'(v.exp_nw));
        for (int k = 0; k < wq.size() && k < v.exp_nw; k++) begin
            wd = words[k / 4];
            chk({tag, " waddr"}, 32'(wq[k].addr), 32'(v.base + 14'(k)));
            chk({tag, " wdata"}, 32'(wq[k].data), 32'(wd[31 - 8 * (k % 4) -: 8]));
        end
    endtask

    logic [31:0] pcs[4];

    initial begin
        //        base      cnt    w0            w1            vdly poke err nw
        vt[0] = '{14'h0066, 12'd1, 32'h0,        32'h0,        0,   0,   1,  0};
        vt[1] = '{14'h0100, 12'd0, 32'h0,        32'h0,        0,   0,   0,  0};
        vt[2] = '{14'h0000, 12'd2, 32'h49400000, 32'h49410004, 0,   0,   0,  8};
        vt[3] = '{14'h0064, 12'd1, 32'hCAFEF00D, 32'h0,        3,   0,   0,  4};
        vt[4] = '{14'h3FFC, 12'd2, 32'h0,        32'h0,        0,   0,   1,  0};
        vt[5] = '{14'h3FFC, 12'd1, 32'hDEADBEEF, 32'h0,        0,   0,   0,  4};
        vt[6] = '{14'h0300, 12'd1, 32'hA1B2C3D4, 32'h0,        2,   1,   0,  4};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.load_base = '0; bus.load_count = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.fetch_pc = 32'h12345678;
        step(); step();
        chk("reset in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset mem_we", 32'(bus.mem_we), 32'd0);
        chk("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk("reset cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("reset mem_addr", 32'(bus.mem_addr), 32'h1678);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            do_load(vt[i], $sformatf("vec%0d", i));
            if (i == 0) chk("hold after bad request", 32'(bus.cpu_hold), 32'd1);
            step();
        end

        // Reset after two bytes of the first word.
        wq.delete();
        bus.start = 1'b1; bus.load_base = 14'h0200; bus.load_count = 12'd2;
        step();
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h11223344;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midreset mem_we", 32'(bus.mem_we), 32'd0);
        chk("midreset cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("midreset err", 32'(bus.err), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset bytes", 32'(wq.size()), 32'd2);
        step();
        rst_n = 1'b1;
        step();
        chk("midreset hold persists", 32'(bus.cpu_hold), 32'd1);
        do_load('{14'h0200, 12'd2, 32'h11223344, 32'h55667788, 0, 0, 0, 8}, "reload");

        // Fetch PC owns the address port in IDLE.
        pcs[0] = 32'h0; pcs[1] = 32'h00003FFF; pcs[2] = 32'hFFFFC123; pcs[3] = 32'h00012344;
        for (int i = 0; i < 4; i++) begin
            bus.fetch_pc = pcs[i];
            #1;
            chk("pc mux", 32'(bus.mem_addr), 32'(pcs[i][13:0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
